ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  E->M pipeline register of the 5-stage Y86-64 pipeline; latches execute-stage results for the memory stage.
//  Also holds the architectural condition-code register (ZF/SF/OF) that execute reads for jXX/cmovXX.
//  Supports stall (hold), bubble (inject nop) and CC write suppression when an exception is downstream.
// PARAMETERS
//  W_DATA   64  datapath width for valE/valA
//  RNONE    15  register id meaning "no register"
//  I_NOP    1   icode injected on bubble/reset
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   asynchronous active-high reset
//  M_stall  in   1   hold all M_* registers this cycle
//  M_bubble in   1   load nop bubble into M_* this cycle
//  e_stat   in   2   execute status (00 AOK, 01 HLT, 10 ADR, 11 INS)
//  e_icode  in   4   execute icode
//  e_cnd    in   1   execute condition result (jXX/cmovXX)
//  e_valE   in   64  ALU result
//  e_valA   in   64  pass-through valA
//  e_dstE   in   4   destination E (already RNONE if cmov not taken)
//  e_dstM   in   4   destination M
//  e_ZF/e_SF/e_OF in 1 each  flags computed by execute this cycle
//  m_stat   in   2   status currently in memory stage
//  W_stat   in   2   status currently in writeback stage
//  M_stat   out  2   registered status
//  M_icode  out  4   registered icode
//  M_cnd    out  1   registered condition
//  M_valE   out  64  registered valE
//  M_valA   out  64  registered valA
//  M_dstE   out  4   registered dstE
//  M_dstM   out  4   registered dstM
//  cc_ZF/cc_SF/cc_OF out 1 each  condition-code register
//  set_cc   out  1   combinational: CC write enable this cycle
// BEHAVIOUR
//  - rst=1 (async, any time incl. mid-stall): M_icode=I_NOP, M_stat=00, M_cnd=0, M_valE=M_valA=0,
//    M_dstE=M_dstM=RNONE, cc_ZF=1, cc_SF=0, cc_OF=0. Held while rst high.
//  - Per rising edge, M_* priority: M_stall > M_bubble > normal load.
//    stall: all M_* hold. bubble: reset values of M_* loaded (CC unaffected by bubble path).
//    normal: M_x <= e_x for every field; latency exactly 1 cycle.
//  - M_stall and M_bubble both high: stall wins, no bubble inserted, no fields change.
//  - set_cc = (e_icode==6) && (m_stat==00) && (W_stat==00) && !rst. Independent of M_stall/M_bubble.
//  - CC update on edge when set_cc=1: {cc_ZF,cc_SF,cc_OF} <= {e_ZF,e_SF,e_OF}; otherwise hold.
//  - OPq followed by HLT/ADR/INS already in M or W: flags not written (precise exceptions).
//  - Non-OPq icodes (incl. cmov/jXX) never modify CC.
//  - e_stat passes unchanged on load; register never alters status except bubble/reset -> AOK.
//  - No internal arithmetic; widths pass through unchanged, no truncation or extension.
//  - Outputs are pure register outputs (except set_cc); no combinational e_*->M_* path.
// TESTING
//  1 rst pulse mid-run with M_icode=6,valE=0x55 -> M_icode=1,dstE=15,valE=0,ZF=1 immediately (before edge).
//  2 e_icode=6,e_valE=0xFFFFFFFFFFFFFFF0,e_SF=1,m/W_stat=00 -> next edge M_valE=..F0, cc_SF=1,cc_ZF=0.
//  3 same as 2 but m_stat=11 -> M_* loaded, set_cc=0, CC unchanged (ZF=1,SF=0,OF=0).
//  4 M_bubble=1 with e_icode=5,e_dstM=3 -> M_icode=1,M_dstM=15,M_stat=00; CC still updated if e_icode=6.
//  5 M_stall=1 and M_bubble=1 for 3 cycles, varying e_* -> M_* constant; released -> loads current e_*.
//  6 back-to-back OPq (addq then subq giving 0) -> cc_ZF=0 after 1st edge, cc_ZF=1 after 2nd.

Source files
------------

// File: rtl/ex_mem_if.sv
// ex_mem_if: the E->M pipeline register's bus.
//   master : drives the execute-stage results (e_*), the downstream status
//            (m_stat, W_stat) and the pipeline controls (M_stall, M_bubble).
//            Reads back the memory-stage registers (M_*), the condition codes
//            (cc_*) and set_cc.
//   slave  : the register itself (ex_mem_reg).
interface ex_mem_if #(
    parameter int W_DATA = 64
);
    logic              M_stall;
    logic              M_bubble;
    logic [1:0]        e_stat;
    logic [3:0]        e_icode;
    logic              e_cnd;
    logic [W_DATA-1:0] e_valE;
    logic [W_DATA-1:0] e_valA;
    logic [3:0]        e_dstE;
    logic [3:0]        e_dstM;
    logic              e_ZF;
    logic              e_SF;
    logic              e_OF;
    logic [1:0]        m_stat;
    logic [1:0]        W_stat;

    logic [1:0]        M_stat;
    logic [3:0]        M_icode;
    logic              M_cnd;
    logic [W_DATA-1:0] M_valE;
    logic [W_DATA-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic              cc_ZF;
    logic              cc_SF;
    logic              cc_OF;
    logic              set_cc;

    modport master (
        output M_stall, M_bubble, e_stat, e_icode, e_cnd, e_valE, e_valA,
               e_dstE, e_dstM, e_ZF, e_SF, e_OF, m_stat, W_stat,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
               cc_ZF, cc_SF, cc_OF, set_cc
    );

    modport slave (
        input  M_stall, M_bubble, e_stat, e_icode, e_cnd, e_valE, e_valA,
               e_dstE, e_dstM, e_ZF, e_SF, e_OF, m_stat, W_stat,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
               cc_ZF, cc_SF, cc_OF, set_cc
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: E->M pipeline register of the 5-stage Y86-64 pipeline, plus the
// architectural condition-code register (ZF/SF/OF) read by execute.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (M_* -> nop bubble, CC -> ZF=1)
//   bus  ex_mem_if.slave: e_* / m_stat / W_stat / M_stall / M_bubble in,
//        M_* / cc_* / set_cc out
// M_* priority per edge: stall (hold) > bubble (load nop) > load e_*.
// CC is written only by OPq and only when no exception sits in M or W, so a
// faulting instruction ahead of an OPq never sees flags it should not.
module ex_mem_reg #(
    parameter int         W_DATA = 64,
    parameter logic [3:0] RNONE  = 4'd15,
    parameter logic [3:0] I_NOP  = 4'd1
) (
    input  logic   clk,
    input  logic   rst,
    ex_mem_if.slave bus
);
    localparam logic [3:0] I_OPQ   = 4'd6;
    localparam logic [1:0] STAT_AOK = 2'b00;

    typedef struct packed {
        logic [1:0]        stat;
        logic [3:0]        icode;
        logic              cnd;
        logic [W_DATA-1:0] valE;
        logic [W_DATA-1:0] valA;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
    } m_reg_t;

    localparam m_reg_t M_NOP = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        valE:  '0,
        valA:  '0,
        dstE:  RNONE,
        dstM:  RNONE
    };

    m_reg_t     m_q;
    m_reg_t     e_in;
    logic [2:0] cc_q;   // {ZF, SF, OF}
    logic       set_cc;

    assign e_in = '{
        stat:  bus.e_stat,
        icode: bus.e_icode,
        cnd:   bus.e_cnd,
        valE:  bus.e_valE,
        valA:  bus.e_valA,
        dstE:  bus.e_dstE,
        dstM:  bus.e_dstM
    };

    // Deliberately blind to stall/bubble: the flags belong to the OPq in
    // execute, not to whatever ends up latched in M.
    assign set_cc = (bus.e_icode == I_OPQ) && (bus.m_stat == STAT_AOK) &&
                    (bus.W_stat == STAT_AOK) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q  <= M_NOP;
            cc_q <= 3'b100;
        end else begin
            if (!bus.M_stall) begin
                m_q <= bus.M_bubble ? M_NOP : e_in;
            end
            if (set_cc) begin
                cc_q <= {bus.e_ZF, bus.e_SF, bus.e_OF};
            end
        end
    end

    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.valE;
    assign bus.M_valA  = m_q.valA;
    assign bus.M_dstE  = m_q.dstE;
    assign bus.M_dstM  = m_q.dstM;
    assign bus.cc_ZF   = cc_q[2];
    assign bus.cc_SF   = cc_q[1];
    assign bus.cc_OF   = cc_q[0];
    assign bus.set_cc  = set_cc;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed, table-driven check of ex_mem_reg plus hand-written
// sequences for stall+bubble holding, mid-cycle async reset and CC suppression.
module tb_ex_mem_reg;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ex_mem_if #(.W_DATA(64)) bus ();

    ex_mem_reg #(.W_DATA(64), .RNONE(4'd15), .I_NOP(4'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic [1:0]  e_stat;
        logic [3:0]  e_icode;
        logic        e_cnd;
        logic [63:0] e_valE;
        logic [63:0] e_valA;
        logic [3:0]  e_dstE;
        logic [3:0]  e_dstM;
        logic [2:0]  e_flags;   // {ZF,SF,OF}
        logic [1:0]  m_stat;
        logic [1:0]  W_stat;
        logic        x_set_cc;
        logic [1:0]  x_stat;
        logic [3:0]  x_icode;
        logic        x_cnd;
        logic [63:0] x_valE;
        logic [63:0] x_valA;
        logic [3:0]  x_dstE;
        logic [3:0]  x_dstM;
        logic [2:0]  x_cc;      // {ZF,SF,OF} after the edge
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic bubble, input logic [1:0] st,
                         input logic [3:0] ic, input logic cnd, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] fl, input logic [1:0] ms, input logic [1:0] ws);
        bus.M_stall  = stall;
        bus.M_bubble = bubble;
        bus.e_stat   = st;
        bus.e_icode  = ic;
        bus.e_cnd    = cnd;
        bus.e_valE   = ve;
        bus.e_valA   = va;
        bus.e_dstE   = de;
        bus.e_dstM   = dm;
        {bus.e_ZF, bus.e_SF, bus.e_OF} = fl;
        bus.m_stat   = ms;
        bus.W_stat   = ws;
    endtask

    task automatic chk_m(input string tag, input logic [1:0] st, input logic [3:0] ic,
                         input logic cnd, input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm, input logic [2:0] cc);
        chk({tag, " M_stat"},  64'(bus.M_stat),  64'(st));
        chk({tag, " M_icode"}, 64'(bus.M_icode), 64'(ic));
        chk({tag, " M_cnd"},   64'(bus.M_cnd),   64'(cnd));
        chk({tag, " M_valE"},  bus.M_valE,       ve);
        chk({tag, " M_valA"},  bus.M_valA,       va);
        chk({tag, " M_dstE"},  64'(bus.M_dstE),  64'(de));
        chk({tag, " M_dstM"},  64'(bus.M_dstM),  64'(dm));
        chk({tag, " cc"},      64'({bus.cc_ZF, bus.cc_SF, bus.cc_OF}), 64'(cc));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(0, 0, 2'd0, 4'd0, 0, 64'h0, 64'h0, 4'd15, 4'd15, 3'b000, 2'd0, 2'd0);

        //           stl bub st    ic     cnd valE                   valA      dstE   dstM   flags    m_stat W_stat | set st  ic     cnd valE                   valA      dstE   dstM   cc
        vecs[0]  = '{0, 0, 2'd0, 4'd2, 1, 64'h1111,             64'h2222, 4'd3,  4'd15, 3'b111, 2'd0, 2'd0,  0, 2'd0, 4'd2, 1, 64'h1111,             64'h2222, 4'd3,  4'd15, 3'b100};
        vecs[1]  = '{0, 0, 2'd0, 4'd6, 0, 64'hFFFFFFFFFFFFFFF0, 64'h5,    4'd2,  4'd15, 3'b010, 2'd0, 2'd0,  1, 2'd0, 4'd6, 0, 64'hFFFFFFFFFFFFFFF0, 64'h5,    4'd2,  4'd15, 3'b010};
        vecs[2]  = '{0, 0, 2'd0, 4'd6, 0, 64'h7,                64'h8,    4'd4,  4'd15, 3'b101, 2'd3, 2'd0,  0, 2'd0, 4'd6, 0, 64'h7,                64'h8,    4'd4,  4'd15, 3'b010};
        vecs[3]  = '{0, 0, 2'd2, 4'd6, 0, 64'h9,                64'hA,    4'd5,  4'd15, 3'b111, 2'd0, 2'd1,  0, 2'd2, 4'd6, 0, 64'h9,                64'hA,    4'd5,  4'd15, 3'b010};
        vecs[4]  = '{0, 1, 2'd0, 4'd5, 0, 64'h20,               64'h30,   4'd15, 4'd3,  3'b000, 2'd0, 2'd0,  0, 2'd0, 4'd1, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b010};
        vecs[5]  = '{0, 1, 2'd0, 4'd6, 1, 64'h40,               64'h50,   4'd6,  4'd15, 3'b100, 2'd0, 2'd0,  1, 2'd0, 4'd1, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b100};
        vecs[6]  = '{1, 0, 2'd0, 4'd3, 0, 64'hAB,               64'hCD,   4'd7,  4'd15, 3'b010, 2'd0, 2'd0,  0, 2'd0, 4'd1, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b100};
        vecs[7]  = '{1, 0, 2'd0, 4'd6, 0, 64'h1,                64'h2,    4'd8,  4'd15, 3'b001, 2'd0, 2'd0,  1, 2'd0, 4'd1, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b001};
        vecs[8]  = '{0, 0, 2'd0, 4'd7, 1, 64'h400,              64'h10,   4'd15, 4'd15, 3'b111, 2'd0, 2'd0,  0, 2'd0, 4'd7, 1, 64'h400,              64'h10,   4'd15, 4'd15, 3'b001};
        vecs[9]  = '{0, 0, 2'd0, 4'd6, 0, 64'h5,                64'h3,    4'd2,  4'd15, 3'b000, 2'd0, 2'd0,  1, 2'd0, 4'd6, 0, 64'h5,                64'h3,    4'd2,  4'd15, 3'b000};
        vecs[10] = '{0, 0, 2'd0, 4'd6, 0, 64'h0,                64'h5,    4'd2,  4'd15, 3'b100, 2'd0, 2'd0,  1, 2'd0, 4'd6, 0, 64'h0,                64'h5,    4'd2,  4'd15, 3'b100};
        vecs[11] = '{0, 0, 2'd1, 4'd0, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b011, 2'd0, 2'd0,  0, 2'd1, 4'd0, 0, 64'h0,                64'h0,    4'd15, 4'd15, 3'b100};
        vecs[12] = '{0, 0, 2'd0, 4'd5, 1, 64'h100,              64'h0,    4'd15, 4'd4,  3'b000, 2'd0, 2'd2,  0, 2'd0, 4'd5, 1, 64'h100,              64'h0,    4'd15, 4'd4,  3'b100};

        // Reset: asynchronous, visible before any clock edge.
        #1 rst = 1'b1;
        #1 chk_m("reset", 2'd0, 4'd1, 0, 64'h0, 64'h0, 4'd15, 4'd15, 3'b100);
        bus.e_icode = 4'd6;
        #1 chk("reset set_cc", 64'(bus.set_cc), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: drive at negedge, check set_cc before the edge, M/CC after.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].bubble, vecs[i].e_stat, vecs[i].e_icode,
                  vecs[i].e_cnd, vecs[i].e_valE, vecs[i].e_valA, vecs[i].e_dstE,
                  vecs[i].e_dstM, vecs[i].e_flags, vecs[i].m_stat, vecs[i].W_stat);
            #1 chk($sformatf("v%0d set_cc", i), 64'(bus.set_cc), 64'(vecs[i].x_set_cc));
            @(posedge clk);
            #1 chk_m($sformatf("v%0d", i), vecs[i].x_stat, vecs[i].x_icode, vecs[i].x_cnd,
                     vecs[i].x_valE, vecs[i].x_valA, vecs[i].x_dstE, vecs[i].x_dstM, vecs[i].x_cc);
            @(negedge clk);
        end

        // Stall and bubble together for 3 cycles: M holds the v12 contents.
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 2'(c), 4'(c + 2), 1, 64'(c * 3 + 1), 64'(c + 9), 4'(c), 4'(c + 1),
                  3'b000, 2'd0, 2'd1);
            @(posedge clk);
            #1 chk_m($sformatf("stall+bubble c%0d", c), 2'd0, 4'd5, 1, 64'h100, 64'h0,
                     4'd15, 4'd4, 3'b100);
            @(negedge clk);
        end
        drive(0, 0, 2'd0, 4'd2, 0, 64'h77, 64'h88, 4'd9, 4'd15, 3'b000, 2'd0, 2'd0);
        @(posedge clk);
        #1 chk_m("release", 2'd0, 4'd2, 0, 64'h77, 64'h88, 4'd9, 4'd15, 3'b100);
        @(negedge clk);

        // Mid-run reset: load an OPq first, then assert rst between edges.
        drive(0, 0, 2'd0, 4'd6, 0, 64'h55, 64'h1, 4'd3, 4'd15, 3'b000, 2'd0, 2'd0);
        @(posedge clk);
        #1 chk_m("pre-rst", 2'd0, 4'd6, 0, 64'h55, 64'h1, 4'd3, 4'd15, 3'b000);
        @(negedge clk);
        bus.M_stall = 1'b1;
        #2 rst = 1'b1;
        #1 chk_m("mid rst", 2'd0, 4'd1, 0, 64'h0, 64'h0, 4'd15, 4'd15, 3'b100);
        chk("mid rst set_cc", 64'(bus.set_cc), 64'h0);
        @(posedge clk);
        #1 chk_m("rst held", 2'd0, 4'd1, 0, 64'h0, 64'h0, 4'd15, 4'd15, 3'b100);
        @(negedge clk);
        rst = 1'b0;

        // OPq with INS in M straight out of reset: CC keeps its reset value.
        drive(0, 0, 2'd0, 4'd6, 0, 64'hFFFFFFFFFFFFFFF0, 64'h0, 4'd2, 4'd15, 3'b010, 2'd3, 2'd0);
        #1 chk("ins-in-M set_cc", 64'(bus.set_cc), 64'h0);
        @(posedge clk);
        #1 chk_m("ins-in-M", 2'd0, 4'd6, 0, 64'hFFFFFFFFFFFFFFF0, 64'h0, 4'd2, 4'd15, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
